cmp_seq: RTL and testbench



---
 rtl/cmp_seq_pkg.sv | 17 +
 rtl/cmp_chunk.sv | 12 +
 rtl/cmp_seq.sv | 109 ++++++++++
 tb/tb_cmp_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_seq_pkg.sv
// Shared types and sizing helpers for the iterative chunked equality comparator.
package cmp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for NCHUNK chunks, never narrower than one bit
    function automatic int calc_iw(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit equality of one operand slice.
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_ne
);

    assign o_ne = (i_a != i_b);

endmodule

// File: rtl/cmp_seq.sv
// Multi-cycle equality comparator scanning CHUNK bits per cycle from the LSB chunk.
// Define CMP_SEQ_EARLY_EXIT_EN to stop at the first mismatch; default scans all chunks in constant time.
module cmp_seq
    import cmp_seq_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int CHUNK = 8,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int IW     = calc_iw(WIDTH, CHUNK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             eq,
    output logic [IW-1:0]    mismatch_idx
);

    state_t            r_state;
    logic [WIDTH-1:0]  r_d1;
    logic [WIDTH-1:0]  r_d2;
    logic [IW-1:0]     r_idx;
    logic              r_sticky;
    logic [IW-1:0]     r_mis_idx;
    logic              r_eq;
    logic              r_done_vld;

    logic [CHUNK-1:0]  w_c1;
    logic [CHUNK-1:0]  w_c2;
    logic              w_chunk_ne;
    logic              w_first_mis;
    logic              w_last;
    logic              w_finish;

    assign w_c1 = r_d1[int'(r_idx) * CHUNK +: CHUNK];
    assign w_c2 = r_d2[int'(r_idx) * CHUNK +: CHUNK];

    cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
        .i_a  (w_c1),
        .i_b  (w_c2),
        .o_ne (w_chunk_ne)
    );

    assign w_first_mis = w_chunk_ne && !r_sticky;
    assign w_last      = (r_idx == IW'(NCHUNK - 1));

`ifdef CMP_SEQ_EARLY_EXIT_EN
    assign w_finish = w_last || w_first_mis;
`else
    assign w_finish = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_d1       <= '0;
            r_d2       <= '0;
            r_idx      <= '0;
            r_sticky   <= 1'b0;
            r_mis_idx  <= '0;
            r_eq       <= 1'b0;
            r_done_vld <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_d1      <= d1;
                        r_d2      <= d2;
                        r_idx     <= '0;
                        r_sticky  <= 1'b0;
                        r_mis_idx <= '0;
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_first_mis) begin
                        r_sticky  <= 1'b1;
                        r_mis_idx <= r_idx;
                    end
                    // eq folds in this cycle's compare since the sticky flag lands on the same edge
                    if (w_finish) begin
                        r_eq       <= !(r_sticky || w_chunk_ne);
                        r_done_vld <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        r_done_vld <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign start_ready  = (r_state == IDLE);
    assign done_valid   = r_done_vld;
    assign eq           = r_eq;
    assign mismatch_idx = r_mis_idx;

endmodule

// File: tb/tb_cmp_seq.sv
// Directed plus randomized checks of cmp_seq (WIDTH=128, CHUNK=8) against a chunk-level reference model.
module tb_cmp_seq;

    localparam int WIDTH  = 128;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = 16;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             done_valid;
    logic             done_ready;
    logic             eq;
    logic [3:0]       mismatch_idx;

    int checks = 0;
    int passed = 0;

    cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .d1           (d1),
        .d2           (d2),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .eq           (eq),
        .mismatch_idx (mismatch_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [WIDTH-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Lowest chunk whose bytes differ; NCHUNK when the operands are equal
    function automatic int ref_first(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        x = a ^ b;
        for (int i = 0; i < NCHUNK; i++)
            if (((x >> (i * CHUNK)) & 128'hFF) != 0) return i;
        return NCHUNK;
    endfunction

    function automatic int ref_lat(input int k);
`ifdef CMP_SEQ_EARLY_EXIT_EN
        return (k < NCHUNK) ? k + 1 : NCHUNK;
`else
        return NCHUNK;
`endif
    endfunction

    // Issue one request, wait for done_valid, check latency and result; leaves the result pending
    task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit scramble, input string tag);
        int k;
        int lat;
        k = ref_first(a, b);
        chk({tag, ":start_ready"}, 32'(start_ready), 32'd1);
        d1 = a;
        d2 = b;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        lat = 0;
        while (!done_valid && lat < 40) begin
            if (scramble) begin
                d1 = rnd128();
                d2 = rnd128();
            end
            step();
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), 32'(ref_lat(k)));
        chk({tag, ":eq"}, 32'(eq), (k == NCHUNK) ? 32'd1 : 32'd0);
        chk({tag, ":mismatch_idx"}, 32'(mismatch_idx), (k == NCHUNK) ? 32'd0 : 32'(k));
    endtask

    task automatic finish_req(input string tag);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk({tag, ":done_valid_low"}, 32'(done_valid), 32'd0);
        chk({tag, ":start_ready_back"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               k;
        int               mode;

        rst_n       = 1'b0;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        d1          = '0;
        d2          = '0;
        step();
        step();
        chk("reset:start_ready", 32'(start_ready), 32'd1);
        chk("reset:done_valid", 32'(done_valid), 32'd0);
        chk("reset:eq", 32'(eq), 32'd0);
        chk("reset:mismatch_idx", 32'(mismatch_idx), 32'd0);
        rst_n = 1'b1;
        step();

        a = {16{8'hA5}};
        run(a, a, 1'b0, "equal_a5");
        finish_req("equal_a5");

        a = rnd128();
        run(a, a ^ (128'h1 << 37), 1'b0, "bit37");
        finish_req("bit37");

        a = rnd128();
        run(a, a ^ (128'h1 << 20) ^ (128'h1 << 100), 1'b0, "bits20_100");

        // Result stays pending for 10 cycles while a new request is offered
        k = ref_first(a, a ^ (128'h1 << 20) ^ (128'h1 << 100));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start_valid = 1'b1;
                d1 = rnd128();
                d2 = rnd128();
            end else begin
                start_valid = 1'b0;
            end
            step();
            chk("hold:done_valid", 32'(done_valid), 32'd1);
            chk("hold:start_ready", 32'(start_ready), 32'd0);
            chk("hold:eq", 32'(eq), 32'd0);
            chk("hold:mismatch_idx", 32'(mismatch_idx), 32'(k));
        end
        start_valid = 1'b0;
        finish_req("hold");
        step();
        chk("hold:no_accept_rdy", 32'(start_ready), 32'd1);
        chk("hold:no_accept_done", 32'(done_valid), 32'd0);

        a = rnd128();
        run(a, a, 1'b1, "scramble_eq");
        finish_req("scramble_eq");

        a = rnd128();
        b = a ^ (128'h3 << 72);
        run(a, b, 1'b1, "scramble_ne");
        finish_req("scramble_ne");

        // Leave eq=1 from a prior result so the mid-scan reset has something to clear
        a = rnd128();
        run(a, a, 1'b0, "pre_reset");
        finish_req("pre_reset");
        d1 = a;
        d2 = a ^ (128'h1 << 8);
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset:start_ready", 32'(start_ready), 32'd1);
        chk("midreset:done_valid", 32'(done_valid), 32'd0);
        chk("midreset:eq", 32'(eq), 32'd0);
        chk("midreset:mismatch_idx", 32'(mismatch_idx), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        a = rnd128();
        run(a, a ^ (128'h1 << 127), 1'b0, "msb_after_reset");
        finish_req("msb_after_reset");

        for (int n = 0; n < 16; n++) begin
            a = rnd128();
            b = a;
            mode = $urandom_range(0, 2);
            if (mode == 1) begin
                b = a ^ (128'h1 << $urandom_range(0, WIDTH - 1));
            end else if (mode == 2) begin
                for (int j = 0; j < 3; j++)
                    b = b ^ (128'(($urandom_range(1, 255))) << (CHUNK * $urandom_range(0, NCHUNK - 1)));
            end
            run(a, b, $urandom_range(0, 1) == 1, "random");
            finish_req("random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
